cmd_tx_sequencer: RTL and testbench

CMD_TX_SEQUENCER -- requirements
Module: cmd_tx_sequencer

---
 rtl/cmd_tx_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cmd_tx_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_tx_sequencer.sv
// cmd_tx_sequencer: sends one 48-bit command frame as six bytes to a
// parallel-to-serial wrapper, one byte per enable/complete exchange.
// Optional feature: define CMD_TX_CRC7_EN to put a real CRC7 in the last byte.
// Without it, the CRC field is all ones and no CRC logic is built.
//
// Wrapper handshake: the sequencer raises ser_enable with a byte on
// ser_parallel. It keeps both stable until ser_complete is seen high on a
// rising edge while in WAIT. ser_enable then drops for exactly one cycle
// (GAP) before the next byte. ser_complete outside WAIT has no effect.
module cmd_tx_sequencer #(
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         ser_enable,
  output logic [N-1:0] ser_parallel,
  input  logic         ser_complete,
  output logic [2:0]   fsm_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [TW-1:0] timer;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;
  logic [6:0]    crc_field;

`ifdef CMD_TX_CRC7_EN
  // CRC7 with polynomial x^7+x^3+1 and seed 0, taken MSB first over 40 bits
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // The latched fields are stable for the whole frame, so the CRC is
  // settled long before the last byte is loaded.
  always_comb begin
    crc_field = crc7({2'b01, idx_q, arg_q});
  end
`else
  // With no CRC the field is fixed, so the last byte is 8'hFF.
  always_comb begin
    crc_field = 7'h7F;
  end
`endif

  // Selects frame byte k, most significant byte first.
  function automatic logic [7:0] frame_byte(input logic [2:0] k,
                                            input logic [5:0] idx,
                                            input logic [31:0] arg,
                                            input logic [6:0] crc);
    logic [7:0] b;
    case (k)
      3'd0:    b = {2'b01, idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      default: b = {crc, 1'b1};
    endcase
    return b;
  endfunction

  assign fsm_state = state;

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= 3'd0;
      timer        <= '0;
      idx_q        <= 6'd0;
      arg_q        <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      ser_enable   <= 1'b0;
      ser_parallel <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        // DONE and ERR accept start as well, so a start held high gives
        // back-to-back frames with busy low only in the done/error cycle.
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            idx_q        <= cmd_index;
            arg_q        <= cmd_argument;
            cnt          <= 3'd0;
            timer        <= '0;
            busy         <= 1'b1;
            ser_enable   <= 1'b1;
            ser_parallel <= {2'b01, cmd_index};
            state        <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion arriving in the same cycle as the timeout wins.
          if (ser_complete) begin
            ser_enable <= 1'b0;
            state      <= ST_GAP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            ser_enable <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            state      <= ST_ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt < 3'd5) begin
            cnt          <= cnt + 3'd1;
            timer        <= '0;
            ser_enable   <= 1'b1;
            ser_parallel <= frame_byte(cnt + 3'd1, idx_q, arg_q, crc_field);
            state        <= ST_LOAD;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          busy       <= 1'b0;
          ser_enable <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_tx_sequencer.sv
// Bench for cmd_tx_sequencer: directed command frames, a wrapper model that
// completes each byte 8 cycles after enable, and a scoreboard monitor.
module tb_cmd_tx_sequencer;

  localparam int TIMEOUT = 64;

  logic        sd_clock = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        busy;
  logic        done;
  logic        error;
  logic        ser_enable;
  logic [7:0]  ser_parallel;
  logic        ser_complete;
  logic [2:0]  fsm_state;

  cmd_tx_sequencer #(.N(8), .TIMEOUT(TIMEOUT)) dut (
    .sd_clock     (sd_clock),
    .reset        (reset),
    .start        (start),
    .cmd_index    (cmd_index),
    .cmd_argument (cmd_argument),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .ser_enable   (ser_enable),
    .ser_parallel (ser_parallel),
    .ser_complete (ser_complete),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sd_clock = ~sd_clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];   // expected bytes in order
  logic [7:0] end_q[$];   // expected frame endings: "D" done, "E" error
  int cyc = 0;
  int cur_byte = 0;       // bytes seen so far in the current frame
  int stall_byte = -1;    // wrapper withholds completion of this byte number

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frames carry the CRC7 byte; without CRC the last byte is FF.
  function automatic logic [47:0] fix_crc(input logic [47:0] f);
`ifdef CMD_TX_CRC7_EN
    return f;
`else
    return {f[47:8], 8'hFF};
`endif
  endfunction

  // ---------------- wrapper model ----------------
  initial begin
    int en_cycles;
    en_cycles = 0;
    ser_complete = 1'b0;
    forever begin
      @(negedge sd_clock);
      if (ser_enable && !reset) begin
        en_cycles++;
        ser_complete = (en_cycles == 8) && (cur_byte != stall_byte);
      end else begin
        en_cycles = 0;
        ser_complete = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit prev_en, prev_done;
    int gap_len, last_rise;
    logic [7:0] held, e;
    prev_en = 0; prev_done = 0; gap_len = 0; last_rise = 0; held = 0;
    forever begin
      @(negedge sd_clock);
      cyc++;
      if (reset) begin
        prev_en = 0; prev_done = 0; cur_byte = 0; gap_len = 0;
      end else begin
        if (ser_enable && !prev_en) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {56'd0, ser_parallel}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("byte", {56'd0, ser_parallel}, {56'd0, e});
          end
          if (cur_byte > 0) check("gap_len", gap_len, 1);
          cur_byte++;
          gap_len = 0;
          held = ser_parallel;
          last_rise = cyc;
        end else if (ser_enable) begin
          check("byte_stable", {56'd0, ser_parallel}, {56'd0, held});
        end else if (busy) begin
          gap_len++;
        end
        if (done || error) begin
          if (end_q.size() == 0) begin
            check("unexpected_end", {62'd0, done, error}, 64'd0);
          end else begin
            e = end_q.pop_front();
            check("frame_end", done ? 64'h44 : 64'h45, {56'd0, e});
          end
          check("end_busy", busy, 0);
          check("end_enable", ser_enable, 0);
          if (done) check("done_bytes", cur_byte, 6);
          if (error) check("timeout_latency", cyc - last_rise, TIMEOUT + 1);
          cur_byte = 0;
        end
        if (done && prev_done) check("done_width", 2, 1);
        prev_en = ser_enable;
        prev_done = done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [47:0] f, input int nbytes, input logic [7:0] ending);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(f[47 - 8*i -: 8]);
    end_q.push_back(ending);
  endtask

  task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg);
    cmd_index = idx;
    cmd_argument = arg;
    start = 1'b1;
    @(negedge sd_clock);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge sd_clock);
      if (done || error) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sd_clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; cmd_index = 6'd0; cmd_argument = 32'd0;
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_enable", ser_enable, 0);
    check("rst_parallel", ser_parallel, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;
    idle(4);
    check("idle_no_frame", busy, 0);

    // CMD0, argument 0
    push_frame(fix_crc(48'h40_00_00_00_00_95), 6, "D");
    pulse_start(6'd0, 32'h0);
    wait_end("cmd0", 400);
    idle(3);

    // CMD8 with inputs changed and a stray start mid-frame
    push_frame(fix_crc(48'h48_00_00_01_AA_87), 6, "D");
    pulse_start(6'd8, 32'h0000_01AA);
    idle(20);
    check("busy_mid_frame", busy, 1);
    cmd_index = 6'h3F;
    cmd_argument = 32'hDEAD_BEEF;
    start = 1'b1;
    @(negedge sd_clock);
    start = 1'b0;
    wait_end("cmd8", 400);
    idle(30);
    check("cmd8_bytes_drained", exp_q.size(), 0);
    check("cmd8_single_end", end_q.size(), 0);

    // CMD55 with completion withheld on the third byte
    stall_byte = 3;
    push_frame(fix_crc(48'h77_00_00_00_00_65), 3, "E");
    pulse_start(6'd55, 32'h0);
    wait_end("stall", 400);
    stall_byte = -1;
    @(negedge sd_clock);
    check("after_err_busy", busy, 0);
    check("after_err_enable", ser_enable, 0);
    idle(3);

    // CMD41, reset while the fourth byte is waiting
    push_frame(fix_crc(48'h69_40_00_00_00_77), 6, "D");
    pulse_start(6'd41, 32'h4000_0000);
    for (int i = 0; i < 400 && cur_byte < 4; i++) @(negedge sd_clock);
    check("reached_b3", cur_byte, 4);
    idle(3);
    #2 reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_enable", ser_enable, 0);
    check("async_parallel", ser_parallel, 0);
    check("async_done", done, 0);
    check("async_error", error, 0);
    check("async_state", fsm_state, 0);
    exp_q.delete();
    end_q.delete();
    @(negedge sd_clock);
    reset = 1'b0;
    idle(5);
    check("post_reset_idle", busy, 0);
    push_frame(fix_crc(48'h40_00_00_00_00_95), 6, "D");
    pulse_start(6'd0, 32'h0);
    wait_end("post_reset", 400);
    idle(3);

    // start held high: two back-to-back CMD8 frames
    push_frame(fix_crc(48'h48_00_00_01_AA_87), 6, "D");
    push_frame(fix_crc(48'h48_00_00_01_AA_87), 6, "D");
    cmd_index = 6'd8;
    cmd_argument = 32'h0000_01AA;
    start = 1'b1;
    wait_end("b2b_first", 400);
    @(negedge sd_clock);
    check("b2b_busy_restart", busy, 1);
    check("b2b_enable_restart", ser_enable, 1);
    start = 1'b0;
    wait_end("b2b_second", 400);
    idle(20);
    check("b2b_bytes_drained", exp_q.size(), 0);
    check("b2b_ends_drained", end_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
